// File: rtl/mandel_view_ctrl.sv
// ============================================================================
// Module      : mandel_view_ctrl
// Description : Turns Basys3 buttons/switches into Mandelbrot view parameters
//               (centre, scale, iteration limit) with press + auto-repeat,
//               saturating Q3.22 arithmetic and a one-cycle restart pulse.
//               Optional auto-zoom animation: define MANDEL_VIEW_ANIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandel_view_ctrl #(
   parameter int HOLD_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int PAN_SHIFT  = 3,
   parameter int COORD_LIM  = 8388608,
   parameter int SCALE_MAX  = 65536,
   parameter int ITER_STEP  = 32,
   parameter int ITER_MIN   = 16,
   parameter int ANIM_CYC   = 2_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_u,
   input  logic               btn_d,
   input  logic               btn_l,
   input  logic               btn_r,
   input  logic               btn_c,
   input  logic               sw_zoom,
   input  logic               sw_auto,
   output logic signed [24:0] center_x_q,
   output logic signed [24:0] center_y_q,
   output logic signed [24:0] scale_q,
   output logic        [11:0] iters_q,
   output logic               restart
);

   // Action codes: button codes are (button bit index + 1), so a larger
   // code means a higher-priority button.
   typedef enum logic [2:0] {
      ACT_NONE = 3'd0,
      ACT_R    = 3'd1,
      ACT_L    = 3'd2,
      ACT_D    = 3'd3,
      ACT_U    = 3'd4,
      ACT_C    = 3'd5,
      ACT_ANIM = 3'd6
   } act_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   localparam logic signed [24:0] CX_RST    = -25'sd2097152;
   localparam logic signed [24:0] CY_RST    = 25'sd0;
   localparam logic signed [24:0] SC_RST    = 25'sd39322;
   localparam logic        [11:0] IT_RST    = 12'd256;
   localparam logic        [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
   localparam logic        [31:0] REP_LAST  = 32'(REPEAT_CYC - 1);
   localparam logic signed [26:0] LIM27     = 27'(COORD_LIM);
   localparam logic signed [26:0] SMAX27    = 27'(SCALE_MAX);
   localparam logic signed [13:0] ISTEP14   = 14'(ITER_STEP);
   localparam logic signed [13:0] IMIN14    = 14'(ITER_MIN);
   localparam logic signed [13:0] IMAX14    = 14'sd4095;

   // Bit order of the synchronised button vector: {C, U, D, L, R}
   logic [5:0]  sync1, sync2;
   logic [4:0]  btn_s, btn_prev, rise, hi_mask, hi_rise;
   logic        zoom_s, zoom_q, sel_level;
   logic [1:0]  warm;
   state_t      state, state_n;
   logic [31:0] cnt, cnt_n;
   act_t        sel, sel_n, fire_act, act_go, act_q;

   logic signed [26:0] sc27, step27, cx27, cy27;
   logic signed [13:0] it14;
   logic signed [24:0] n_cx, n_cy, n_sc;
   logic        [11:0] n_it;
   logic               force_pulse, changed;

   // Highest-priority button present in a vector of rising edges
   function automatic act_t pick(input logic [4:0] v);
      act_t res;
      res = ACT_NONE;
      for (int i = 0; i < 5; i++) begin
         if (v[i]) res = act_t'(3'(i + 1));
      end
      return res;
   endfunction

   function automatic logic signed [24:0] sat_coord(input logic signed [26:0] v);
      if (v > LIM27)       return LIM27[24:0];
      else if (v < -LIM27) return (-LIM27);
      else                 return v[24:0];
   endfunction

   function automatic logic signed [24:0] sat_scale(input logic signed [26:0] v);
      if (v < 27'sd1)       return 25'sd1;
      else if (v > SMAX27)  return SMAX27[24:0];
      else                  return v[24:0];
   endfunction

   function automatic logic [11:0] sat_iter(input logic signed [13:0] v);
      if (v < IMIN14)       return IMIN14[11:0];
      else if (v > IMAX14)  return IMAX14[11:0];
      else                  return v[11:0];
   endfunction

   // Two-flop synchronisers for buttons and the mode switch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sw_zoom, btn_c, btn_u, btn_d, btn_l, btn_r};
         sync2 <= sync1;
      end
   end

   assign btn_s  = sync2[4:0];
   assign zoom_s = sync2[5];

   // Edge detection is held off until the synchronisers carry real samples,
   // so a button still held across reset is not mistaken for a new press.
   assign rise = (warm == 2'd3) ? (btn_s & ~btn_prev) : 5'd0;

   // Buttons that outrank the currently selected one
   always_comb begin
      hi_mask = 5'b11111;
      case (sel)
         ACT_R:   hi_mask = 5'b11110;
         ACT_L:   hi_mask = 5'b11100;
         ACT_D:   hi_mask = 5'b11000;
         ACT_U:   hi_mask = 5'b10000;
         ACT_C:   hi_mask = 5'b00000;
         default: hi_mask = 5'b11111;
      endcase
   end

   assign hi_rise = rise & hi_mask;

   // Level of the button currently owning the hold/repeat sequence
   always_comb begin
      sel_level = 1'b0;
      case (sel)
         ACT_R:   sel_level = btn_s[0];
         ACT_L:   sel_level = btn_s[1];
         ACT_D:   sel_level = btn_s[2];
         ACT_U:   sel_level = btn_s[3];
         ACT_C:   sel_level = btn_s[4];
         default: sel_level = 1'b0;
      endcase
   end

   // Press / hold / auto-repeat sequencer: next state and fired action
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sel_n    = sel;
      fire_act = ACT_NONE;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (rise != 5'd0) begin
               fire_act = pick(rise);
               sel_n    = fire_act;
               state_n  = S_HOLD;
            end
         end
         S_HOLD, S_REPEAT: begin
            if (hi_rise != 5'd0) begin
               fire_act = pick(hi_rise);
               sel_n    = fire_act;
               state_n  = S_HOLD;
               cnt_n    = '0;
            end else if (!sel_level) begin
               state_n = S_IDLE;
               sel_n   = ACT_NONE;
               cnt_n   = '0;
            end else if (cnt == ((state == S_HOLD) ? HOLD_LAST : REP_LAST)) begin
               fire_act = sel;
               state_n  = S_REPEAT;
               cnt_n    = '0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         default: begin
            state_n = S_IDLE;
            sel_n   = ACT_NONE;
            cnt_n   = '0;
         end
      endcase
   end

`ifdef MANDEL_VIEW_ANIM_EN
   logic        auto1, auto_s;
   logic [31:0] anim_cnt, anim_cnt_n;
   localparam logic [31:0] ANIM_LAST = 32'(ANIM_CYC - 1);

   // Synchroniser and period counter for the auto-zoom request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto1    <= 1'b0;
         auto_s   <= 1'b0;
         anim_cnt <= '0;
      end else begin
         auto1    <= sw_auto;
         auto_s   <= auto1;
         anim_cnt <= anim_cnt_n;
      end
   end

   // Animation steps only while idle; any button action pre-empts it
   always_comb begin
      act_go     = fire_act;
      anim_cnt_n = '0;
      if (state == S_IDLE && auto_s && fire_act == ACT_NONE) begin
         if (anim_cnt == ANIM_LAST) act_go = ACT_ANIM;
         else                       anim_cnt_n = anim_cnt + 32'd1;
      end
   end
`else
   logic unused_anim;
   assign unused_anim = sw_auto ^ (ANIM_CYC == 0);
   assign act_go      = fire_act;
`endif

   // Sequencer state plus the registered action handed to the update stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         sel      <= ACT_NONE;
         btn_prev <= '0;
         warm     <= '0;
         act_q    <= ACT_NONE;
         zoom_q   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         sel      <= sel_n;
         btn_prev <= btn_s;
         warm     <= (warm == 2'd3) ? 2'd3 : warm + 2'd1;
         act_q    <= act_go;
         zoom_q   <= zoom_s;
      end
   end

   // Saturating parameter update for the registered action
   always_comb begin
      sc27        = {{2{scale_q[24]}}, scale_q};
      step27      = sc27 <<< PAN_SHIFT;
      cx27        = {{2{center_x_q[24]}}, center_x_q};
      cy27        = {{2{center_y_q[24]}}, center_y_q};
      it14        = {2'b00, iters_q};
      n_cx        = center_x_q;
      n_cy        = center_y_q;
      n_sc        = scale_q;
      n_it        = iters_q;
      force_pulse = 1'b0;
      case (act_q)
         ACT_C: begin
            n_cx        = CX_RST;
            n_cy        = CY_RST;
            n_sc        = SC_RST;
            n_it        = IT_RST;
            force_pulse = 1'b1;
         end
         ACT_U: begin
            if (zoom_q) n_sc = sat_scale(sc27 >>> 1);
            else        n_cy = sat_coord(cy27 - step27);
         end
         ACT_D: begin
            if (zoom_q) n_sc = sat_scale(sc27 <<< 1);
            else        n_cy = sat_coord(cy27 + step27);
         end
         ACT_L: begin
            if (zoom_q) n_it = sat_iter(it14 - ISTEP14);
            else        n_cx = sat_coord(cx27 - step27);
         end
         ACT_R: begin
            if (zoom_q) n_it = sat_iter(it14 + ISTEP14);
            else        n_cx = sat_coord(cx27 + step27);
         end
`ifdef MANDEL_VIEW_ANIM_EN
         ACT_ANIM: begin
            if (sc27 <= 27'sd1 || (sc27 >>> 4) == 27'sd0) begin
               n_cx = CX_RST;
               n_cy = CY_RST;
               n_sc = SC_RST;
               n_it = IT_RST;
            end else begin
               n_sc = sat_scale(sc27 - (sc27 >>> 4));
            end
         end
`endif
         default: ;
      endcase
      changed = force_pulse || (n_cx != center_x_q) || (n_cy != center_y_q) ||
                (n_sc != scale_q) || (n_it != iters_q);
   end

   // Output parameter registers and restart pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         center_x_q <= CX_RST;
         center_y_q <= CY_RST;
         scale_q    <= SC_RST;
         iters_q    <= IT_RST;
         restart    <= 1'b0;
      end else begin
         center_x_q <= n_cx;
         center_y_q <= n_cy;
         scale_q    <= n_sc;
         iters_q    <= n_it;
         restart    <= changed;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mandel_view_ctrl.sv
// ============================================================================
// Module      : tb_mandel_view_ctrl
// Description : Directed self-checking bench for mandel_view_ctrl with short
//               hold/repeat/animation periods.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandel_view_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
   logic sw_zoom = 1'b0, sw_auto = 1'b0;
   logic signed [24:0] cx, cy, sc;
   logic        [11:0] it;
   logic               restart;

   int checks = 0;
   int failures = 0;
   int pulses = 0;
   int cyc = 0;
   int ptime[$];

   localparam int STEP = 314576;   // 39322 << 3

   mandel_view_ctrl #(
      .HOLD_CYC   (8),
      .REPEAT_CYC (4),
      .ANIM_CYC   (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_u      (btn_u),
      .btn_d      (btn_d),
      .btn_l      (btn_l),
      .btn_r      (btn_r),
      .btn_c      (btn_c),
      .sw_zoom    (sw_zoom),
      .sw_auto    (sw_auto),
      .center_x_q (cx),
      .center_y_q (cy),
      .scale_q    (sc),
      .iters_q    (it),
      .restart    (restart)
   );

   always #5 clk = ~clk;

   // Count restart pulses and remember when they happened
   always @(negedge clk) begin
      cyc++;
      if (restart === 1'b1) begin
         pulses++;
         ptime.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mask bits {C,U,D,L,R}
   task automatic set_btn(input logic [4:0] m);
      {btn_c, btn_u, btn_d, btn_l, btn_r} = m;
   endtask

   task automatic press(input logic [4:0] m);
      set_btn(m);
      tick(3);
      set_btn(5'd0);
      tick(5);
   endtask

   function automatic int gap(input int b, input int k);
      if (ptime.size() > b + k) return ptime[b + k] - ptime[b + k - 1];
      return -1;
   endfunction

   initial begin
      int p0, b;

      // ---- 1: reset values ----
      tick(3);
      chk("rst_cx", cx, -2097152);
      chk("rst_restart_in_reset", restart, 0);
      #3 rst_n = 1'b1;
      p0 = pulses;
      tick(20);
      chk("idle_cx", cx, -2097152);
      chk("idle_cy", cy, 0);
      chk("idle_scale", sc, 39322);
      chk("idle_iters", it, 256);
      chk("idle_pulses", pulses - p0, 0);

      // ---- 2: single pan right, latency N+3 ----
      p0 = pulses;
      set_btn(5'b00001);
      tick(1);                      // edge N sampled the press
      tick(2);                      // edge N+2
      chk("lat_cx_before", cx, -2097152);
      chk("lat_restart_before", restart, 0);
      tick(1);                      // edge N+3
      chk("lat_cx_after", cx, -1782576);
      chk("lat_restart_after", restart, 1);
      tick(2);
      set_btn(5'd0);
      tick(15);
      chk("pan_r_pulses", pulses - p0, 1);
      chk("pan_r_cx_final", cx, -1782576);

      // ---- 3: hold down, auto-repeat spacing ----
      p0 = pulses;
      b  = ptime.size();
      set_btn(5'b00100);
      tick(19);
      set_btn(5'd0);
      tick(10);
      chk("rep_pulses", pulses - p0, 4);
      chk("rep_cy", cy, 4 * STEP);
      chk("rep_gap_hold", gap(b, 1), 8);
      chk("rep_gap_rep1", gap(b, 2), 4);
      chk("rep_gap_rep2", gap(b, 3), 4);

      // ---- 4: zoom in down to the scale floor ----
      sw_zoom = 1'b1;
      tick(4);
      p0 = pulses;
      press(5'b01000);
      chk("zoom1_scale", sc, 19661);
      repeat (3) press(5'b01000);
      chk("zoom4_scale", sc, 2457);
      repeat (11) press(5'b01000);
      chk("zoom15_scale", sc, 1);
      chk("zoom15_pulses", pulses - p0, 15);
      p0 = pulses;
      repeat (2) press(5'b01000);
      chk("zoom_floor_scale", sc, 1);
      chk("zoom_floor_pulses", pulses - p0, 0);

      // ---- 5: iterations saturate high, centre resets ----
      p0 = pulses;
      repeat (200) press(5'b00001);
      chk("iter_max", it, 4095);
      chk("iter_max_pulses", pulses - p0, 120);
      p0 = pulses;
      press(5'b10000);
      chk("c_iters", it, 256);
      chk("c_cx", cx, -2097152);
      chk("c_cy", cy, 0);
      chk("c_scale", sc, 39322);
      chk("c_pulses", pulses - p0, 1);
      p0 = pulses;
      repeat (9) press(5'b00010);
      chk("iter_min", it, 16);
      chk("iter_min_pulses", pulses - p0, 8);
      p0 = pulses;
      repeat (2) press(5'b00100);
      chk("zoom_out_max", sc, 65536);
      chk("zoom_out_pulses", pulses - p0, 1);
      p0 = pulses;
      press(5'b10000);
      chk("c_again_pulses", pulses - p0, 1);
      chk("c_again_scale", sc, 39322);

      // ---- 6: priority and reset while repeating ----
      sw_zoom = 1'b0;
      tick(4);
      p0 = pulses;
      press(5'b10010);
      chk("prio_cx", cx, -2097152);
      chk("prio_pulses", pulses - p0, 1);
      set_btn(5'b01000);
      tick(17);
      chk("hold_u_cy", cy, -3 * STEP);
      #2 rst_n = 1'b0;
      #1;
      chk("async_cy", cy, 0);
      chk("async_cx", cx, -2097152);
      chk("async_restart", restart, 0);
      tick(3);
      #3 rst_n = 1'b1;
      p0 = pulses;
      tick(30);
      chk("post_rst_pulses", pulses - p0, 0);
      chk("post_rst_cy", cy, 0);
      set_btn(5'd0);
      tick(6);
      p0 = pulses;
      press(5'b01000);
      chk("repress_cy", cy, -STEP);
      chk("repress_pulses", pulses - p0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
